// File: rtl/reg_bank_if.sv
// Bus bundle for the 16x16 register file: one write port from the writeback mux,
// two read ports toward the ALU operand paths, and the status flags.
interface reg_bank_if;
   logic [15:0] mux_data;
   logic [3:0]  mux_data_addr;
   logic        mux_data_write;
   logic [3:0]  a_addr;
   logic        a_read;
   logic [3:0]  b_addr;
   logic        b_read;
   logic [15:0] a_data;
   logic [15:0] b_data;
   logic [2:0]  flag;

   modport master (
      output mux_data, mux_data_addr, mux_data_write,
      output a_addr, a_read, b_addr, b_read,
      input  a_data, b_data, flag
   );

   modport slave (
      input  mux_data, mux_data_addr, mux_data_write,
      input  a_addr, a_read, b_addr, b_read,
      output a_data, b_data, flag
   );
endinterface

// File: rtl/reg_bank.sv
// Sixteen-entry, 16-bit register file: one synchronous write port, two registered
// read ports with write-to-read bypass, and registered status flags.
module reg_bank (
   input logic       CLK,
   input logic       RST,
   reg_bank_if.slave bus
);
   localparam int unsigned DEPTH = 16;

   logic [15:0] regs [DEPTH];
   logic [15:0] a_next;
   logic [15:0] b_next;
   logic        a_hit;
   logic        b_hit;

   // A read of the address being written this edge must see the incoming value.
   always_comb begin
      a_hit  = bus.mux_data_write && (bus.mux_data_addr == bus.a_addr);
      b_hit  = bus.mux_data_write && (bus.mux_data_addr == bus.b_addr);
      a_next = regs[bus.a_addr];
      b_next = regs[bus.b_addr];
      if (a_hit) a_next = bus.mux_data;
      if (b_hit) b_next = bus.mux_data;
   end

   // NOTE: the array is reset on purpose (R0-R15 must read zero after reset); that
   // keeps it in flops rather than a RAM macro, which is fine at 16 entries.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (bus.mux_data_write) begin
         // NOTE: non-blocking so every reader this edge samples the pre-edge contents.
         regs[bus.mux_data_addr] <= bus.mux_data;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.a_data <= '0;
         bus.b_data <= '0;
         bus.flag   <= '0;
      end else begin
         if (bus.a_read) bus.a_data <= a_next;
         if (bus.b_read) bus.b_data <= b_next;
         bus.flag <= {bus.mux_data_write, bus.a_read, bus.b_read};
      end
   end
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_reg_bank;
   logic clk;
   logic rst;
   logic chk_en;
   int   checks   = 0;
   int   failures = 0;

   reg_bank_if bus ();

   reg_bank dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: apply the write first, then reads see the updated array,
   // which yields the bypass behaviour directly.
   logic [15:0] m_regs [16];
   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [2:0]  m_flag;

   always @(posedge clk or posedge rst) begin
      logic        w, ar, br;
      logic [3:0]  wa, aa, ba;
      logic [15:0] wd;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
         m_a    = 16'h0000;
         m_b    = 16'h0000;
         m_flag = 3'b000;
      end else begin
         w  = bus.mux_data_write;
         wa = bus.mux_data_addr;
         wd = bus.mux_data;
         ar = bus.a_read;
         aa = bus.a_addr;
         br = bus.b_read;
         ba = bus.b_addr;
         if (w)  m_regs[wa] = wd;
         if (ar) m_a = m_regs[aa];
         if (br) m_b = m_regs[ba];
         m_flag = {w, ar, br};
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en && !rst) begin
         check("model_a_data", bus.a_data, m_a);
         check("model_b_data", bus.b_data, m_b);
         check("model_flag", {13'b0, bus.flag}, {13'b0, m_flag});
      end
   end

   task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                        input logic ar, input logic [3:0] aa,
                        input logic br, input logic [3:0] ba);
      @(negedge clk);
      bus.mux_data_write = w;
      bus.mux_data_addr  = wa;
      bus.mux_data       = wd;
      bus.a_read         = ar;
      bus.a_addr         = aa;
      bus.b_read         = br;
      bus.b_addr         = ba;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
   endtask

   initial begin
      chk_en = 1'b0;
      rst    = 1'b1;
      bus.mux_data_write = 1'b0;
      bus.mux_data_addr  = 4'd0;
      bus.mux_data       = 16'h0000;
      bus.a_read         = 1'b0;
      bus.a_addr         = 4'd0;
      bus.b_read         = 1'b0;
      bus.b_addr         = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a_data", bus.a_data, 16'h0000);
      check("reset_flag", {13'b0, bus.flag}, 16'h0000);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;

      // Write then dual read
      drive(1'b1, 4'd0, 16'h1010, 1'b0, 4'd0, 1'b0, 4'd0);
      check("flag_after_write0", {13'b0, bus.flag}, 16'h0004);
      idle();
      check("flag_idle", {13'b0, bus.flag}, 16'h0000);
      drive(1'b1, 4'd1, 16'h2020, 1'b0, 4'd0, 1'b0, 4'd0);
      check("flag_after_write1", {13'b0, bus.flag}, 16'h0004);
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b1, 4'd1);
      check("dual_read_a", bus.a_data, 16'h1010);
      check("dual_read_b", bus.b_data, 16'h2020);
      check("dual_read_flag", {13'b0, bus.flag}, 16'h0003);

      // Hold: port B disabled with a new address keeps its last value
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b0, 4'd5);
      check("hold_b_data", bus.b_data, 16'h2020);
      check("hold_flag", {13'b0, bus.flag}, 16'h0002);
      drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd5);
      check("reread_b_r5", bus.b_data, 16'h0000);
      check("reread_a_held", bus.a_data, 16'h1010);
      check("reread_flag", {13'b0, bus.flag}, 16'h0001);

      // Bypass on both ports
      drive(1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd3, 1'b1, 4'd3);
      check("bypass_a", bus.a_data, 16'hBEEF);
      check("bypass_b", bus.b_data, 16'hBEEF);
      check("bypass_flag", {13'b0, bus.flag}, 16'h0007);

      // Full sweep with mirrored pairs
      for (int i = 0; i < 16; i++)
         drive(1'b1, 4'(i), 16'(16'hA000 + i), 1'b0, 4'd0, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 1'b1, 4'(15 - i));
         check("sweep_a", bus.a_data, 16'(16'hA000 + i));
         check("sweep_b", bus.b_data, 16'(16'hA000 + 15 - i));
      end

      // Write disabled leaves R2 alone
      drive(1'b0, 4'd2, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0);
      check("nowrite_flag", {13'b0, bus.flag}, 16'h0000);
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b0, 4'd0);
      check("nowrite_r2", bus.a_data, 16'hA002);

      // Randomized traffic; narrow address window half the time to provoke bypass
      repeat (400) begin
         logic        narrow;
         logic [3:0]  wa, aa, ba;
         narrow = 1'($urandom_range(0, 1));
         wa = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         aa = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         ba = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         drive(1'($urandom_range(0, 1)), wa, 16'($urandom),
               1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ba);
      end

      // Asynchronous reset mid-cycle, then every register reads zero
      idle();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_a", bus.a_data, 16'h0000);
      check("async_rst_b", bus.b_data, 16'h0000);
      check("async_rst_flag", {13'b0, bus.flag}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'(i), 1'b1, 4'(15 - i));
         check("post_rst_a", bus.a_data, 16'h0000);
         check("post_rst_b", bus.b_data, 16'h0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
